// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 frame checker: strips the 2-byte trailer, forwards
// payload, reports one status pulse per frame. Option: CRC_CHK_STATS_EN.
module crc16_frame_checker #(
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             stat_valid,
  output logic             stat_crc_ok,
  output logic             stat_runt,
  output logic             stat_len_err,
  output logic [LEN_W-1:0] frame_len
`ifdef CRC_CHK_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
`endif
);

  localparam logic [15:0] POLY = 16'hC86C;
  localparam logic [15:0] INIT = 16'hFFFF;
  localparam logic [1:0]  OCC0 = 2'd0;
  localparam logic [1:0]  OCC1 = 2'd1;
  localparam logic [1:0]  OCC2 = 2'd2;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic             rdy_en;
  logic [7:0]       h0;
  logic [7:0]       h1;
  logic [1:0]       occ;
  logic [15:0]      lfsr;
  logic [LEN_W-1:0] len_cnt;
  logic [15:0]      lfsr_nxt;
  logic [LEN_W-1:0] len_inc;
  logic             acc;

  // Handshake and next-value terms for the oldest held byte.
  always_comb begin
    in_ready = rdy_en & ~stat_valid & ((occ != OCC2) | out_ready);
    acc      = in_valid & in_ready;
    lfsr_nxt = crc_byte(lfsr, h0);
    len_inc  = (len_cnt == LEN_SAT) ? len_cnt : len_cnt + LEN_W'(1);
  end

  // Delay line, CRC, payload output and per-frame status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en       <= 1'b0;
      h0           <= '0;
      h1           <= '0;
      occ          <= OCC0;
      lfsr         <= INIT;
      len_cnt      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      stat_valid   <= 1'b0;
      stat_crc_ok  <= 1'b0;
      stat_runt    <= 1'b0;
      stat_len_err <= 1'b0;
      frame_len    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (stat_valid) begin
        stat_valid <= 1'b0;
        lfsr       <= INIT;
        occ        <= OCC0;
        len_cnt    <= '0;
      end
      if (acc) begin
        if (occ == OCC2) begin
          out_data  <= h0;
          out_valid <= 1'b1;
          out_last  <= in_last;
          lfsr      <= lfsr_nxt;
          len_cnt   <= len_inc;
          h0        <= h1;
          h1        <= in_data;
        end else if (!in_last) begin
          if (occ == OCC0) h0 <= in_data;
          else             h1 <= in_data;
          occ <= occ + 2'd1;
        end
        if (in_last) begin
          stat_valid <= 1'b1;
          unique case (occ)
            OCC2: begin
              stat_crc_ok  <= ({h1, in_data} == lfsr_nxt);
              stat_runt    <= 1'b0;
              stat_len_err <= (len_inc > LEN_MAX);
              frame_len    <= len_inc;
            end
            OCC1: begin
              stat_crc_ok  <= ({h0, in_data} == INIT);
              stat_runt    <= 1'b0;
              stat_len_err <= 1'b0;
              frame_len    <= '0;
            end
            default: begin
              stat_crc_ok  <= 1'b0;
              stat_runt    <= 1'b1;
              stat_len_err <= 1'b0;
              frame_len    <= '0;
            end
          endcase
        end
      end
    end
  end

`ifdef CRC_CHK_STATS_EN
  logic frame_good;

  assign frame_good = stat_crc_ok & ~stat_runt & ~stat_len_err;

  // Saturating good/bad frame counters, clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (stat_clr) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (stat_valid) begin
      if (frame_good) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/crc16_frame_checker.md
Name: crc16_frame_checker

Overview:
Receive-side counterpart of the team's 8-bit-parallel CRC-16 generator. It accepts a byte stream whose frames end in a 2-byte CRC trailer, sent MSB first. It forwards only the payload bytes downstream, recomputes the CRC over the payload, and reports one status result per frame. It sits between the link deserializer and the packet buffer.

Parameters:
MAX_LEN, 1518, maximum payload bytes per frame (CRC trailer excluded)
LEN_W, 16, width of the payload length counter and frame_len; must satisfy 2^LEN_W > MAX_LEN

Ports:
clk  in  1  single clock domain
rst_n  in  1  asynchronous, active-low reset
in_data  in  8  input byte
in_valid  in  1  input byte valid
in_last  in  1  marks the final byte of a frame, i.e. CRC LSB
in_ready  out  1  checker can accept a byte
out_data  out  8  payload byte
out_valid  out  1  payload byte valid
out_last  out  1  marks the last payload byte
out_ready  in  1  downstream can accept a byte
stat_valid  out  1  one-cycle status pulse per frame
stat_crc_ok  out  1  received CRC matches computed CRC
stat_runt  out  1  frame shorter than 2 bytes
stat_len_err  out  1  payload longer than MAX_LEN
frame_len  out  LEN_W  payload byte count, held until the next stat_valid

Behaviour:
- Reset (async on rst_n low): all outputs 0. lfsr = 0xFFFF, hold count = 0, length counter = 0, in_ready = 0. in_ready rises on the first clk edge after rst_n deasserts.
- CRC function: byte-update equations bit-identical to the team's CRC-16 generator. Polynomial terms x^16+x^15+x^14+x^11+x^6+x^5+x^3+x^2. Init 0xFFFF, no reflection, no final XOR.
- Delay line: holds the 2 most recently accepted bytes (h0 older, h1 newer) plus occupancy occ, which ranges 0..2.
- Handshake rules:
  - in_ready = (occ<2) | out_ready, except in the status cycle, when in_ready = 0.
  - A transfer occurs when valid and ready are both high. out_valid and out_data stay stable until accepted.
- Accept with occ<2 and in_last=0: byte stored, occ+1. No output.
- Accept with occ=2 and in_last=0: h0 is presented on out_data with out_valid=1 and out_last=0. lfsr is updated with h0 and the length counter increments. The delay line shifts.
- Accept with occ=2 and in_last=1:
  - h0 is emitted with out_last=1 and lfsr is updated with h0.
  - The CRC trailer is {h1, in_data}.
  - The comparison is made against the post-update lfsr, captured into a compare register.
- Accept with occ=1 and in_last=1 (zero-payload frame): no payload output; the trailer {h0, in_data} is compared against 0xFFFF.
- Accept with occ=0 and in_last=1 (runt frame): no output; stat_runt=1 and stat_crc_ok=0.
- Status cycle: the cycle after the in_last transfer.
  - stat_valid=1 for exactly one cycle, with the stat_* flags and frame_len valid.
  - Then lfsr=0xFFFF, occ=0 and the length counter clears.
- Length overflow: if the count exceeds MAX_LEN, payload forwarding continues, the counter saturates at MAX_LEN+1, and stat_len_err=1 at the status pulse. stat_crc_ok is still reported.
- Backpressure: when out_valid=1 and out_ready=0, the output and all internal state hold. in_ready=0 while occ=2.
- Reset mid-frame: everything is cleared immediately and no status is produced for the partial frame. Downstream must discard any frame lacking out_last.

Optional Feature:
CRC_CHK_STATS_EN
- Defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - Both are saturating counters, incremented on stat_valid.
  - A frame counts as good only if crc_ok=1, runt=0 and len_err=0; otherwise it counts as bad.
  - Counters reset to 0 on rst_n and are also cleared by a new input, stat_clr, which is synchronous and has priority over increment.
- Undefined: these ports and the counter logic are absent.

Test Plan:
1. Frame FF FF, in_last on byte 2 -> no out_valid; stat_valid one cycle later with crc_ok=1, frame_len=0.
2. Payload 31..39 (9 bytes) + golden-model CRC trailer -> 9 bytes output in order, out_last on 0x39, crc_ok=1, frame_len=9.
3. Same frame with trailer LSB bit 0 flipped -> payload still forwarded, crc_ok=0.
4. Single byte 0xA5 with in_last -> stat_runt=1, crc_ok=0, no output.
5. Random out_ready duty of 30% across 3 back-to-back frames -> byte order and out_last preserved, no loss or duplication, 3 stat pulses.
6. MAX_LEN=4 with a 6-byte payload and valid CRC -> stat_len_err=1, crc_ok=1, frame_len=5. Then rst_n pulsed mid-frame -> outputs 0, next frame checks correctly.
